// File: rtl/uart.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart : full-duplex 8N1 UART, bit period set at runtime by clock_div      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] clock_div,
  input  logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx,
  output logic        tx_done,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] c_min_period = 16'd2;

  // Periods below two cycles cannot place a mid-bit sample, so clamp them.
  logic [15:0] w_period;
  assign w_period = (clock_div < c_min_period) ? c_min_period : clock_div;

  // ---------------------------------------------------------------- transmit
  state_t      r_tx_state, w_tx_state_nx;
  logic        r_tx_prev;
  logic [15:0] r_tx_timer, w_tx_timer_nx;
  logic [15:0] r_tx_period, w_tx_period_nx;
  logic [2:0]  r_tx_bit, w_tx_bit_nx;
  logic [7:0]  r_tx_shift, w_tx_shift_nx;
  logic        r_tx_line, w_tx_line_nx;
  logic        r_tx_done, w_tx_done_nx;
  logic        w_tx_tick;

  assign w_tx_tick = (r_tx_timer == 16'd0);
  assign tx        = r_tx_line;
  assign tx_done   = r_tx_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_state  <= S_IDLE;
      r_tx_prev   <= 1'b0;
      r_tx_timer  <= 16'd0;
      r_tx_period <= c_min_period;
      r_tx_bit    <= 3'd0;
      r_tx_shift  <= 8'd0;
      r_tx_line   <= 1'b1;
      r_tx_done   <= 1'b1;
    end else begin
      r_tx_state  <= w_tx_state_nx;
      r_tx_prev   <= tx_ready;
      r_tx_timer  <= w_tx_timer_nx;
      r_tx_period <= w_tx_period_nx;
      r_tx_bit    <= w_tx_bit_nx;
      r_tx_shift  <= w_tx_shift_nx;
      r_tx_line   <= w_tx_line_nx;
      r_tx_done   <= w_tx_done_nx;
    end
  end

  always_comb begin
    w_tx_state_nx  = r_tx_state;
    w_tx_timer_nx  = r_tx_timer;
    w_tx_period_nx = r_tx_period;
    w_tx_bit_nx    = r_tx_bit;
    w_tx_shift_nx  = r_tx_shift;
    w_tx_line_nx   = r_tx_line;
    w_tx_done_nx   = r_tx_done;
    case (r_tx_state)
      S_IDLE: begin
        if (tx_ready && !r_tx_prev) begin
          w_tx_state_nx  = S_START;
          w_tx_shift_nx  = tx_data;
          w_tx_period_nx = w_period;
          w_tx_timer_nx  = w_period - 16'd1;
          w_tx_line_nx   = 1'b0;
          w_tx_done_nx   = 1'b0;
        end
      end
      S_START: begin
        w_tx_timer_nx = r_tx_timer - 16'd1;
        if (w_tx_tick) begin
          w_tx_state_nx = S_DATA;
          w_tx_timer_nx = r_tx_period - 16'd1;
          w_tx_bit_nx   = 3'd0;
          w_tx_line_nx  = r_tx_shift[0];
        end
      end
      S_DATA: begin
        w_tx_timer_nx = r_tx_timer - 16'd1;
        if (w_tx_tick) begin
          w_tx_timer_nx = r_tx_period - 16'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nx = S_STOP;
            w_tx_line_nx  = 1'b1;
          end else begin
            // bit 0 is already on the line, so the next one out is shift[1]
            w_tx_bit_nx   = r_tx_bit + 3'd1;
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
            w_tx_line_nx  = r_tx_shift[1];
          end
        end
      end
      S_STOP: begin
        w_tx_timer_nx = r_tx_timer - 16'd1;
        if (w_tx_tick) begin
          w_tx_state_nx = S_IDLE;
          w_tx_done_nx  = 1'b1;
        end
      end
    endcase
  end

  // ----------------------------------------------------------------- receive
  state_t      r_rx_state, w_rx_state_nx;
  logic        r_rx_meta, r_rx_sync;
  logic [15:0] r_rx_timer, w_rx_timer_nx;
  logic [15:0] r_rx_period, w_rx_period_nx;
  logic [2:0]  r_rx_bit, w_rx_bit_nx;
  logic [7:0]  r_rx_shift, w_rx_shift_nx;
  logic [7:0]  r_rx_data, w_rx_data_nx;
  logic        r_rx_valid, w_rx_valid_nx;
  logic        r_rx_error, w_rx_error_nx;
  logic        r_rx_wait_high, w_rx_wait_high_nx;
  logic        w_rx_tick;

  assign w_rx_tick = (r_rx_timer == 16'd0);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_error  = r_rx_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta      <= 1'b1;
      r_rx_sync      <= 1'b1;
      r_rx_state     <= S_IDLE;
      r_rx_timer     <= 16'd0;
      r_rx_period    <= c_min_period;
      r_rx_bit       <= 3'd0;
      r_rx_shift     <= 8'd0;
      r_rx_data      <= 8'd0;
      r_rx_valid     <= 1'b0;
      r_rx_error     <= 1'b0;
      r_rx_wait_high <= 1'b0;
    end else begin
      r_rx_meta      <= rx;
      r_rx_sync      <= r_rx_meta;
      r_rx_state     <= w_rx_state_nx;
      r_rx_timer     <= w_rx_timer_nx;
      r_rx_period    <= w_rx_period_nx;
      r_rx_bit       <= w_rx_bit_nx;
      r_rx_shift     <= w_rx_shift_nx;
      r_rx_data      <= w_rx_data_nx;
      r_rx_valid     <= w_rx_valid_nx;
      r_rx_error     <= w_rx_error_nx;
      r_rx_wait_high <= w_rx_wait_high_nx;
    end
  end

  always_comb begin
    w_rx_state_nx     = r_rx_state;
    w_rx_timer_nx     = r_rx_timer;
    w_rx_period_nx    = r_rx_period;
    w_rx_bit_nx       = r_rx_bit;
    w_rx_shift_nx     = r_rx_shift;
    w_rx_data_nx      = r_rx_data;
    w_rx_valid_nx     = 1'b0;
    w_rx_error_nx     = 1'b0;
    w_rx_wait_high_nx = r_rx_wait_high;
    case (r_rx_state)
      S_IDLE: begin
        // A framing error leaves the line possibly stuck low; require a high
        // level before treating the next low as a start bit.
        if (r_rx_wait_high) begin
          if (r_rx_sync) w_rx_wait_high_nx = 1'b0;
        end else if (!r_rx_sync) begin
          w_rx_state_nx  = S_START;
          w_rx_period_nx = w_period;
          w_rx_timer_nx  = {1'b0, w_period[15:1]} - 16'd1;
        end
      end
      S_START: begin
        w_rx_timer_nx = r_rx_timer - 16'd1;
        if (w_rx_tick) begin
          if (r_rx_sync) begin
            w_rx_state_nx = S_IDLE;
          end else begin
            w_rx_state_nx = S_DATA;
            w_rx_timer_nx = r_rx_period - 16'd1;
            w_rx_bit_nx   = 3'd0;
          end
        end
      end
      S_DATA: begin
        w_rx_timer_nx = r_rx_timer - 16'd1;
        if (w_rx_tick) begin
          w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_timer_nx = r_rx_period - 16'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nx = S_STOP;
          else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
        end
      end
      S_STOP: begin
        w_rx_timer_nx = r_rx_timer - 16'd1;
        if (w_rx_tick) begin
          w_rx_state_nx = S_IDLE;
          if (r_rx_sync) begin
            w_rx_data_nx  = r_rx_shift;
            w_rx_valid_nx = 1'b1;
          end else begin
            w_rx_error_nx     = 1'b1;
            w_rx_wait_high_nx = 1'b1;
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart : scoreboard bench for uart, random data against a frame model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] clock_div;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        tx_done;
  logic        rx;
  logic        rx_drv;
  logic        loopback;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;

  assign rx = loopback ? tx : rx_drv;

  uart dut (
    .clock     (clock),
    .reset     (reset),
    .clock_div (clock_div),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_done   (tx_done),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [7:0] data; int period; int start; } tx_exp_t;
  typedef struct { logic err; logic [7:0] data; int start; int period; } rx_exp_t;
  tx_exp_t    tx_q[$];
  rx_exp_t    rx_q[$];
  logic [7:0] last_good;

  function automatic int eff_period(input logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  // Frame position n: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return d[n-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transmit monitor: each frame is compared cycle by cycle to the expected waveform.
  initial begin : tx_mon
    tx_exp_t e;
    bit      aborted;
    bit      bit_ok;
    forever begin
      @(negedge clock);
      if (reset && !tx_done) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected_frame: got frame starting at cycle %0d, expected none", cyc);
          for (int k = 0; k < 1400000 && reset && !tx_done; k++) @(negedge clock);
        end else begin
          e = tx_q.pop_front();
          check("tx_start_latency", 32'(cyc), 32'(e.start));
          aborted = 1'b0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            bit_ok = 1'b1;
            for (int c = 0; c < e.period; c++) begin
              if (b != 0 || c != 0) @(negedge clock);
              if (!reset) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== frame_bit(e.data, b) || tx_done !== 1'b0) bit_ok = 1'b0;
            end
            if (!aborted) check($sformatf("tx_bit%0d_byte%02h", b, e.data), 32'(bit_ok), 32'd1);
          end
          if (!aborted) begin
            @(negedge clock);
            if (reset) begin
              check("tx_done_after_10P", 32'(tx_done), 32'd1);
              check("tx_line_idle", 32'(tx), 32'd1);
            end
          end
        end
      end
    end
  end

  // Receive monitor.
  initial begin : rx_mon
    rx_exp_t r;
    int      lat;
    forever begin
      @(negedge clock);
      if (reset && (rx_valid || rx_error)) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected_pulse: got valid=%b error=%b data=%02h, expected no pulse",
                   rx_valid, rx_error, rx_data);
        end else begin
          r = rx_q.pop_front();
          lat = cyc - r.start;
          check("rx_kind", 32'({rx_valid, rx_error}), r.err ? 32'd1 : 32'd2);
          check("rx_data", 32'(rx_data), 32'(r.data));
          check("rx_latency_in_window",
                32'(lat >= 9 * r.period && lat <= 10 * r.period + 5), 32'd1);
        end
      end
    end
  end

  task automatic start_tx(input logic [7:0] d, input logic [15:0] div, input bit expect_frame,
                          output int s);
    tx_exp_t e;
    rx_exp_t r;
    @(negedge clock);
    if (tx_ready) begin
      tx_ready = 1'b0;
      @(negedge clock);
    end
    tx_data   = d;
    clock_div = div;
    tx_ready  = 1'b1;
    s = cyc + 1;
    if (expect_frame) begin
      e.data = d; e.period = eff_period(div); e.start = s;
      tx_q.push_back(e);
      if (loopback) begin
        r.err = 1'b0; r.data = d; r.start = s; r.period = eff_period(div);
        rx_q.push_back(r);
        last_good = d;
      end
    end
  endtask

  task automatic wait_tx_idle(input int limit);
    int k = 0;
    @(negedge clock);
    while (!tx_done && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (!tx_done) begin
      n_checks++;
      $display("FAIL tx_done_timeout: got tx_done=0 after %0d cycles, expected 1", limit);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int p, input int extra_low);
    rx_exp_t r;
    @(negedge clock);
    r.err = !stop; r.data = stop ? d : last_good; r.start = cyc; r.period = p;
    rx_q.push_back(r);
    if (stop) last_good = d;
    for (int n = 0; n < 10; n++) begin
      rx_drv = (n == 9) ? stop : frame_bit(d, n);
      repeat (p) @(negedge clock);
    end
    if (!stop) repeat (extra_low) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2 * p) @(negedge clock);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s;
    bit ok;
    reset = 1'b0; clock_div = 16'd217; tx_data = 8'd0; tx_ready = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0; last_good = 8'd0;
    repeat (3) @(negedge clock);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_tx_done", 32'(tx_done), 32'd1);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_error", 32'(rx_error), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b1;

    ok = 1'b1;
    repeat (1000) begin
      @(negedge clock);
      if (tx !== 1'b1 || tx_done !== 1'b1) ok = 1'b0;
    end
    check("idle_1000_cycles", 32'(ok), 32'd1);

    start_tx(8'h41, 16'd217, 1'b1, s);
    wait_tx_idle(2500);

    // Level held high must not retransmit; a fresh edge must.
    start_tx(8'h55, 16'd50, 1'b1, s);
    wait_tx_idle(600);
    repeat (3000) @(negedge clock);
    start_tx(8'h00, 16'd50, 1'b1, s);
    wait_tx_idle(600);

    // Handshake and data changes during a frame are ignored.
    start_tx(8'h3A, 16'd20, 1'b1, s);
    repeat (60) @(negedge clock);
    tx_ready = 1'b0; tx_data = 8'hFF;
    @(negedge clock);
    tx_ready = 1'b1;
    repeat (40) @(negedge clock);
    tx_ready = 1'b0;
    @(negedge clock);
    tx_ready = 1'b1;
    wait_tx_idle(400);
    repeat (100) @(negedge clock);

    // Rising edge landing on the edge where tx_done returns is dropped.
    start_tx(8'h81, 16'd8, 1'b1, s);
    @(negedge clock);
    tx_ready = 1'b0;
    while (cyc < s + 10 * 8 - 1) @(negedge clock);
    tx_ready = 1'b1;
    wait_tx_idle(100);
    repeat (50) @(negedge clock);
    start_tx(8'hC3, 16'd8, 1'b1, s);
    wait_tx_idle(200);

    // Asynchronous reset mid-frame.
    start_tx(8'h00, 16'd10, 1'b1, s);
    repeat (30) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx_high", 32'(tx), 32'd1);
    check("async_reset_tx_done", 32'(tx_done), 32'd1);
    @(negedge clock);
    tx_ready = 1'b0;
    last_good = 8'd0;
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);

    // Loopback: spot value then random bytes and periods.
    loopback = 1'b1;
    start_tx(8'hA5, 16'd16, 1'b1, s);
    wait_tx_idle(300);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      start_tx(8'($urandom), 16'($urandom_range(0, 24)), 1'b1, s);
      wait_tx_idle(400);
      repeat (10) @(negedge clock);
    end
    @(negedge clock);
    loopback = 1'b0;
    tx_ready = 1'b0;

    // Receiver: glitch, framing error with stuck-low line, then a good frame.
    clock_div = 16'd16;
    repeat (5) @(negedge clock);
    rx_drv = 1'b0;
    repeat (3) @(negedge clock);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    send_rx(8'h3C, 1'b0, 16, 48);
    send_rx(8'($urandom), 1'b1, 16, 0);

    // Reset during a receive frame.
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (64) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    rx_drv = 1'b1;
    last_good = 8'd0;
    @(negedge clock);
    reset = 1'b1;
    repeat (400) @(negedge clock);
    check("rx_data_after_reset", 32'(rx_data), 32'(last_good));
    send_rx(8'($urandom), 1'b1, 16, 0);

    repeat (50) @(negedge clock);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1 UART with a runtime-programmable bit period.
- Transmitter takes a byte via a tx_ready/tx_done handshake and serialises it on tx; receiver deserialises rx into bytes.
- Sits between a byte-stream controller (e.g. ROM-driven message sender) and the board serial pins.

Parameters:
- None. Bit timing is set at runtime by clock_div.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- clock_div  input  16  clock cycles per bit; e.g. 217 at 50 MHz gives ~230400 baud
- tx_data  input  8  byte to transmit; sampled on the start cycle
- tx_ready  input  1  transmit request; a 0->1 transition while idle starts a frame
- tx  output  1  serial transmit line, idle high
- tx_done  output  1  high = transmitter idle; low for the whole frame
- rx  input  1  serial receive line, asynchronous, idle high
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse when rx_data updates
- rx_error  output  1  one-cycle pulse on framing error (stop bit low)

Behaviour:
- Reset (async, reset=0):
  - tx=1, tx_done=1, rx_data=0, rx_valid=0, rx_error=0.
  - tx_ready edge detector previous-value register=0.
  - rx synchroniser flops=1.
  - Both FSMs go to IDLE.
  - Asserting reset mid-frame aborts it immediately; tx returns high at once.
- Effective period P:
  - P = clock_div, latched at the start of each TX frame and each RX frame.
  - Values 0 or 1 are treated as 2.
- TX FSM: IDLE -> START -> DATA (8 bits) -> STOP -> IDLE.
  - Start condition: tx_ready=1 and its registered previous value=0, while in IDLE.
  - On that edge: latch tx_data and P, enter START, set tx=0 and tx_done=0.
  - tx_done is therefore low at the first edge after tx_ready rises.
  - Each state holds tx for exactly P cycles.
  - DATA sends bits LSB first (bit 0 first). STOP drives tx=1 for P cycles.
  - At the end of STOP: return to IDLE, tx_done=1. Total frame = 10*P cycles from the start edge.
  - tx_ready held high is level-insensitive: no retransmission until it falls and rises again.
  - tx_ready may drop at any time during a frame without effect.
  - A rising edge during a frame is ignored, not queued.
  - A rising edge coinciding with the cycle tx_done returns high is ignored; the controller must present a fresh 0->1.
  - tx_data changes after the start edge have no effect.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
  - IDLE: on a low level, latch P and wait P/2 cycles (integer divide) to reach mid start bit.
  - If the line is high at that point, it is a false start: return to IDLE with no pulse.
  - Otherwise sample 8 data bits at P-cycle intervals (mid-bit), shifting LSB first.
  - Then sample the stop bit after P more cycles.
  - Stop=1: rx_data <= shifted byte; rx_valid pulses 1 cycle.
  - Stop=0: rx_data unchanged; rx_error pulses 1 cycle.
  - Either way, go to IDLE. After an error, wait for rx high before re-arming.
  - Re-arm after a good frame is immediate (checks for the next low from the next cycle).
- TX and RX are fully independent and may run simultaneously.
- Counter widths:
  - Bit-timer 16 bits, counts P-1 down to 0.
  - Bit index 3 bits.
  - No overflow at P=65535.

Test Plan:
- Reset: hold reset=0 -> tx=1, tx_done=1, rx_valid=0. Release; with tx_ready=0 for 1000 cycles, tx stays 1.
- Single TX, clock_div=217, tx_data=0x41, raise tx_ready:
  - tx_done=0 on the next edge.
  - tx = 0,1,0,0,0,0,0,1,0,1, each held 217 cycles.
  - tx_done returns 1 exactly 2170 cycles after the start edge.
- Handshake/no-duplicate: hold tx_ready=1 for 3000 cycles after a 0x55 frame -> exactly one frame. Then drop for 1 cycle and re-raise with 0x00 -> second frame of all-zero data bits.
- Mid-frame stimulus: during a frame, toggle tx_ready and change tx_data to 0xFF -> original byte sent unchanged, no queued frame.
- RX loopback: tie tx to rx, send 0xA5 with clock_div=16 -> one rx_valid pulse with rx_data=0xA5, about 10*16 cycles after the start edge.
- RX error and glitch, clock_div=16:
  - 3-cycle low pulse on rx -> no pulse.
  - Frame 0x3C with stop bit forced low -> rx_error pulse, rx_data unchanged.
  - Async reset mid-RX-frame -> FSM in IDLE, no pulse.
